// File: rtl/instr_encoder_if.sv
// Field-bundle handshake plus CPU memory write port of the RV32I instruction encoder.
// The master modport is the encoder side; slave is the producer/memory side.
interface instr_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic [31:0] imm;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_byte_enable;
  logic        mem_resp;

  modport master (
    input  in_valid, opcode, funct3, funct7, rs1, rs2, rd, imm, mem_resp,
    output in_ready, mem_write, mem_address, mem_wdata, mem_byte_enable
  );

  modport slave (
    output in_valid, opcode, funct3, funct7, rs1, rs2, rd, imm, mem_resp,
    input  in_ready, mem_write, mem_address, mem_wdata, mem_byte_enable
  );
endinterface

// File: rtl/instr_encoder.sv
// Packs decoded RV32I fields into instruction words and writes them to sequential
// memory addresses; immediates that do not fit their format raise a sticky error.
module instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0060
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [31:0]    start_addr,
  instr_encoder_if.master bus,
  output logic [15:0]    count,
  output logic           err
);
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_CSR   = 7'b1110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_REG   = 7'b0110011;

  typedef enum logic [0:0] {IDLE = 1'b0, WRITE = 1'b1} state_t;

  // Returns {error, word}; the word is don't-care when error is set.
  function automatic logic [32:0] encode_fn(
    input logic [6:0]  op,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [4:0]  r1,
    input logic [4:0]  r2,
    input logic [4:0]  rdst,
    input logic [31:0] im
  );
    logic        e;
    logic [31:0] w;
    e = 1'b0;
    w = 32'd0;
    case (op)
      OP_LUI, OP_AUIPC: begin
        w = {im[31:12], rdst, op};
        e = (im[11:0] != 12'd0);
      end
      OP_JAL: begin
        w = {im[20], im[10:1], im[11], im[19:12], rdst, op};
        e = im[0] | (im[31:20] != {12{im[20]}});
      end
      OP_IMM: begin
        if ((f3 == 3'b001) || (f3 == 3'b101)) begin
          w = {f7, im[4:0], r1, f3, rdst, op};
          e = (im[31:5] != 27'd0);
        end else begin
          w = {im[11:0], r1, f3, rdst, op};
          e = (im[31:11] != {21{im[11]}});
        end
      end
      OP_JALR, OP_LOAD, OP_CSR: begin
        w = {im[11:0], r1, f3, rdst, op};
        e = (im[31:11] != {21{im[11]}});
      end
      OP_STORE: begin
        w = {im[11:5], r2, r1, f3, im[4:0], op};
        e = (im[31:11] != {21{im[11]}});
      end
      OP_BR: begin
        w = {im[12], im[10:5], r2, r1, f3, im[4:1], im[11], op};
        e = im[0] | (im[31:12] != {20{im[12]}});
      end
      OP_REG: begin
        w = {f7, r2, r1, f3, rdst, op};
        e = 1'b0;
      end
      default: begin
        w = 32'd0;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  state_t      state_r, state_s;
  logic        mem_write_r;
  logic [31:0] mem_address_r;
  logic [31:0] mem_wdata_r;
  logic [15:0] count_r;
  logic        err_r;
  logic        in_ready_s;
  logic        hs_s;
  logic        enc_err_s;
  logic [31:0] enc_word_s;

  assign {enc_err_s, enc_word_s} = encode_fn(bus.opcode, bus.funct3, bus.funct7,
                                             bus.rs1, bus.rs2, bus.rd, bus.imm);
  assign in_ready_s = (state_r == IDLE) & ~start;
  assign hs_s       = bus.in_valid & in_ready_s;

  assign bus.in_ready        = in_ready_s;
  assign bus.mem_write       = mem_write_r;
  assign bus.mem_address     = mem_address_r;
  assign bus.mem_wdata       = mem_wdata_r;
  assign bus.mem_byte_enable = 4'hF;
  assign count               = count_r;
  assign err                 = err_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic: only a clean encode starts a write; errors stay in IDLE.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (hs_s && !enc_err_s) begin
          state_s = WRITE;
        end else begin
          state_s = IDLE;
        end
      end
      WRITE: begin
        if (bus.mem_resp) begin
          state_s = IDLE;
        end else begin
          state_s = WRITE;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Output word, address counter, write count and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_write_r   <= 1'b0;
      mem_address_r <= BASE_ADDR;
      mem_wdata_r   <= 32'd0;
      count_r       <= 16'd0;
      err_r         <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            mem_address_r <= {start_addr[31:2], 2'b00};
            count_r       <= 16'd0;
            err_r         <= 1'b0;
          end else if (hs_s) begin
            if (enc_err_s) begin
              err_r <= 1'b1;
            end else begin
              mem_wdata_r <= enc_word_s;
              mem_write_r <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (bus.mem_resp) begin
            mem_write_r   <= 1'b0;
            mem_address_r <= mem_address_r + 32'd4;
            if (count_r != 16'hFFFF) begin
              count_r <= count_r + 16'd1;
            end
          end
        end
        default: mem_write_r <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// Directed plus randomized bench for instr_encoder against a value-level RV32I encoding model.
module tb_instr_encoder;
  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] start_addr;
  logic [15:0] count;
  logic        err;
  int          checks;
  int          failures;

  logic [31:0] exp_addr;
  logic [15:0] exp_count;
  logic        exp_err;
  logic [31:0] seen;

  instr_encoder_if bus();

  instr_encoder #(.BASE_ADDR(32'h0000_0060)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
    .bus(bus), .count(count), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Encoding from the ISA rules: signed ranges as integers, fields placed by shifts.
  function automatic void model(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdst,
                                input logic [31:0] im, output bit e, output logic [31:0] w);
    int s;
    logic [31:0] base;
    s = int'(im);
    base = (32'(f3) << 12) | 32'(op);
    e = 1'b0;
    w = 32'd0;
    case (op)
      7'h37, 7'h17: begin
        e = ((im & 32'hFFF) != 32'd0);
        w = (im & 32'hFFFF_F000) | (32'(rdst) << 7) | 32'(op);
      end
      7'h6F: begin
        e = (s % 2 != 0) || (s < -(1 << 20)) || (s >= (1 << 20));
        w = (((im >> 20) & 32'd1) << 31) | (((im >> 1) & 32'h3FF) << 21) |
            (((im >> 11) & 32'd1) << 20) | (((im >> 12) & 32'hFF) << 12) |
            (32'(rdst) << 7) | 32'(op);
      end
      7'h13, 7'h67, 7'h03, 7'h73: begin
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
          e = (im > 32'd31);
          w = (32'(f7) << 25) | ((im & 32'h1F) << 20) | (32'(r1) << 15) | base | (32'(rdst) << 7);
        end else begin
          e = (s < -2048) || (s > 2047);
          w = ((im & 32'hFFF) << 20) | (32'(r1) << 15) | base | (32'(rdst) << 7);
        end
      end
      7'h23: begin
        e = (s < -2048) || (s > 2047);
        w = (((im >> 5) & 32'h7F) << 25) | (32'(r2) << 20) | (32'(r1) << 15) | base |
            ((im & 32'h1F) << 7);
      end
      7'h63: begin
        e = (s % 2 != 0) || (s < -4096) || (s > 4095);
        w = (((im >> 12) & 32'd1) << 31) | (((im >> 5) & 32'h3F) << 25) | (32'(r2) << 20) |
            (32'(r1) << 15) | base | (((im >> 1) & 32'hF) << 8) | (((im >> 11) & 32'd1) << 7);
      end
      7'h33: begin
        w = (32'(f7) << 25) | (32'(r2) << 20) | (32'(r1) << 15) | base | (32'(rdst) << 7);
      end
      default: e = 1'b1;
    endcase
  endfunction

  task automatic set_fields(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                            input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdst,
                            input logic [31:0] im);
    bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
    bus.rs1 = r1; bus.rs2 = r2; bus.rd = rdst; bus.imm = im;
  endtask

  // One bundle: handshake, then (if encodable) a write completed after 'delay' wait cycles.
  task automatic do_txn(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] rdst,
                        input logic [31:0] im, input int delay, output logic [31:0] word_seen);
    bit e;
    logic [31:0] w;
    int n;
    model(op, f3, f7, r1, r2, rdst, im, e, w);
    set_fields(op, f3, f7, r1, r2, rdst, im);
    bus.in_valid = 1'b1;
    #1;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      step();
      n++;
    end
    check("ready_wait", 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    word_seen = bus.mem_wdata;
    if (e) begin
      exp_err = 1'b1;
      check("err_set", 32'(err), 32'd1);
      check("err_no_write", 32'(bus.mem_write), 32'd0);
      check("err_count", 32'(count), 32'(exp_count));
      check("err_ready", 32'(bus.in_ready), 32'd1);
    end else begin
      check("wr_req", 32'(bus.mem_write), 32'd1);
      check("wr_addr", bus.mem_address, exp_addr);
      check("wr_data", bus.mem_wdata, w);
      for (int i = 0; i < delay; i++) begin
        step();
        check("wr_hold", 32'(bus.mem_write), 32'd1);
        check("wr_hold_data", bus.mem_wdata, w);
      end
      bus.mem_resp = 1'b1;
      step();
      bus.mem_resp = 1'b0;
      exp_addr = exp_addr + 32'd4;
      if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
      check("done_req", 32'(bus.mem_write), 32'd0);
      check("done_addr", bus.mem_address, exp_addr);
      check("done_count", 32'(count), 32'(exp_count));
      check("done_ready", 32'(bus.in_ready), 32'd1);
    end
    check("err_sticky", 32'(err), 32'(exp_err));
  endtask

  logic [6:0] ops [10] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h03, 7'h73, 7'h13, 7'h23, 7'h63, 7'h33};

  initial begin
    logic [31:0] r;
    logic [31:0] im;
    logic [6:0]  op;
    checks = 0;
    failures = 0;
    rst = 1'b1;
    start = 1'b0;
    start_addr = 32'd0;
    bus.in_valid = 1'b0;
    bus.mem_resp = 1'b0;
    set_fields(7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    step();
    step();
    rst = 1'b0;
    #1;
    exp_addr = 32'h60;
    exp_count = 16'd0;
    exp_err = 1'b0;
    check("rst_write", 32'(bus.mem_write), 32'd0);
    check("rst_addr", bus.mem_address, 32'h60);
    check("rst_wdata", bus.mem_wdata, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("byte_en", 32'(bus.mem_byte_enable), 32'hF);

    // Directed program words.
    do_txn(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd5, 0, seen);
    check("tp_addi", seen, 32'h0050_0093);
    do_txn(7'h23, 3'd2, 7'd0, 5'd1, 5'd2, 5'd0, 32'd8, 1, seen);
    check("tp_sw", seen, 32'h0020_A423);
    do_txn(7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 0, seen);
    check("tp_beq", seen, 32'hFE00_0EE3);
    do_txn(7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd5, 32'h1234_5000, 2, seen);
    check("tp_lui", seen, 32'h1234_52B7);
    do_txn(7'h6F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'h0000_0800, 0, seen);
    check("tp_jal", seen, 32'h0010_00EF);
    check("tp_addr", bus.mem_address, 32'h74);

    // Out-of-range / illegal bundles.
    do_txn(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 32'd2048, 0, seen);
    do_txn(7'h63, 3'd1, 7'd0, 5'd1, 5'd2, 5'd0, 32'd7, 0, seen);
    do_txn(7'h7F, 3'd0, 7'd0, 5'd1, 5'd2, 5'd3, 32'd0, 0, seen);
    check("err_addr_kept", bus.mem_address, 32'h74);

    // Stall: mem_resp held low with a second bundle waiting.
    set_fields(7'h33, 3'd0, 7'h20, 5'd3, 5'd4, 5'd5, 32'd0);
    bus.in_valid = 1'b1;
    step();
    set_fields(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd6, 32'd1);
    for (int i = 0; i < 10; i++) begin
      check("stall_ready", 32'(bus.in_ready), 32'd0);
      check("stall_req", 32'(bus.mem_write), 32'd1);
      check("stall_addr", bus.mem_address, 32'h74);
      check("stall_data", bus.mem_wdata, 32'h4041_82B3);
      step();
    end
    bus.mem_resp = 1'b1;
    step();
    bus.mem_resp = 1'b0;
    check("stall_done_req", 32'(bus.mem_write), 32'd0);
    check("stall_done_ready", 32'(bus.in_ready), 32'd1);
    check("stall_done_addr", bus.mem_address, 32'h78);
    step();
    bus.in_valid = 1'b0;
    check("second_req", 32'(bus.mem_write), 32'd1);
    check("second_data", bus.mem_wdata, 32'h0010_0313);
    bus.mem_resp = 1'b1;
    step();
    bus.mem_resp = 1'b0;
    exp_addr = 32'h7C;
    exp_count = exp_count + 16'd2;
    check("second_count", 32'(count), 32'(exp_count));

    // start near the top of the address space, together with in_valid.
    start = 1'b1;
    start_addr = 32'hFFFF_FFFE;
    set_fields(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd3, 32'd1);
    bus.in_valid = 1'b1;
    #1;
    check("start_ready", 32'(bus.in_ready), 32'd0);
    step();
    start = 1'b0;
    check("start_req", 32'(bus.mem_write), 32'd0);
    check("start_err", 32'(err), 32'd0);
    check("start_count", 32'(count), 32'd0);
    check("start_addr", bus.mem_address, 32'hFFFF_FFFC);
    exp_addr = 32'hFFFF_FFFC;
    exp_count = 16'd0;
    exp_err = 1'b0;
    do_txn(7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd3, 32'd1, 0, seen);
    check("wrap_addr", bus.mem_address, 32'h0);

    // Reset in the middle of a write.
    set_fields(7'h33, 3'd0, 7'd0, 5'd1, 5'd1, 5'd1, 32'd0);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("pre_rst_req", 32'(bus.mem_write), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_req", 32'(bus.mem_write), 32'd0);
    check("mid_rst_addr", bus.mem_address, 32'h60);
    check("mid_rst_count", 32'(count), 32'd0);
    bus.mem_resp = 1'b1;
    step();
    bus.mem_resp = 1'b0;
    check("idle_resp_count", 32'(count), 32'd0);
    check("idle_resp_addr", bus.mem_address, 32'h60);
    exp_addr = 32'h60;
    exp_count = 16'd0;
    exp_err = 1'b0;

    // Randomized bundles against the model.
    for (int k = 0; k < 60; k++) begin
      r = $urandom;
      case ($urandom_range(0, 4))
        0: im = r;
        1: im = {{20{r[11]}}, r[11:0]};
        2: im = {{19{r[12]}}, r[12:1], 1'b0};
        3: im = {r[31:12], 12'h000};
        default: im = {{11{r[20]}}, r[20:1], 1'b0};
      endcase
      if ($urandom_range(0, 9) == 0) op = 7'($urandom);
      else op = ops[$urandom_range(0, 9)];
      do_txn(op, 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), im,
             int'($urandom_range(0, 3)), seen);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
